// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcoded control unit for a three-register (A, B, Z) datapath.
//   One instruction is accepted from IDLE, then its control steps are
//   issued one per cycle. Every output comes straight from a flop: the
//   values for the next cycle are decoded from the next state and
//   captured on the same edge as the state itself.
//
// Ports
//   clock              rising-edge clock
//   clear              synchronous active-high reset
//   start              execute the instruction on opcode/imm (taken only in IDLE)
//   opcode[1:0]        00 LDI A,imm | 01 ADDI B,A,imm | 10 MV B,Z | 11 illegal
//   imm[IMM_WIDTH-1:0] instruction immediate
//   busy               high in every state except IDLE
//   done               one-cycle completion pulse (FIN)
//   illegal            one-cycle pulse for opcode 11 (ERR)
//   RAout/RBout/RZout  datapath bus-drive enables
//   RAin/RBin/RZin     datapath register-load enables
//   AddImmediate       immediate for the adder (ADD_T1 only, else zero)
//   RegisterAImmediate immediate loaded into A (LDI_T0 only, else zero)
//   state_dbg[2:0]     current FSM state for observation
//
// Handshake: start is a level request sampled only while the FSM is in
// IDLE; the edge that samples it also latches opcode and imm. While busy
// is high, start/opcode/imm are ignored. A new request can be taken at
// the earliest on the edge after the FIN/ERR cycle, so at least one IDLE
// cycle separates instructions.
module control_sequencer #(
  parameter int IMM_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [1:0]           opcode,
  input  logic [IMM_WIDTH-1:0] imm,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal,
  output logic                 RAout,
  output logic                 RBout,
  output logic                 RZout,
  output logic                 RAin,
  output logic                 RBin,
  output logic                 RZin,
  output logic [IMM_WIDTH-1:0] AddImmediate,
  output logic [IMM_WIDTH-1:0] RegisterAImmediate,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LDI_T0 = 3'd1,
    ADD_T1 = 3'd2,
    ADD_T2 = 3'd3,
    MV_T0  = 3'd4,
    FIN    = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t               state, next_state;
  logic                 accept;
  logic [IMM_WIDTH-1:0] imm_q, imm_d;

  // next-cycle output values, registered below
  logic                 busy_d, done_d, illegal_d;
  logic                 ra_out_d, rb_out_d, rz_out_d;
  logic                 ra_in_d, rb_in_d, rz_in_d;
  logic [IMM_WIDTH-1:0] add_imm_d, rega_imm_d;

  // The opcode is held by the state itself: each opcode selects its own
  // first control state, so only the immediate needs a separate latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          case (opcode)
            2'b00:   next_state = LDI_T0;
            2'b01:   next_state = ADD_T1;
            2'b10:   next_state = MV_T0;
            default: next_state = ERR;
          endcase
        end
      end
      LDI_T0:  next_state = FIN;
      ADD_T1:  next_state = ADD_T2;
      ADD_T2:  next_state = FIN;
      MV_T0:   next_state = FIN;
      FIN:     next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // On the accepting edge the latch is loading imm, so the first control
  // cycle must use the incoming value rather than the stale imm_q.
  assign imm_d = accept ? imm : imm_q;

  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    ra_out_d   = 1'b0;
    rb_out_d   = 1'b0;
    rz_out_d   = 1'b0;
    ra_in_d    = 1'b0;
    rb_in_d    = 1'b0;
    rz_in_d    = 1'b0;
    add_imm_d  = '0;
    rega_imm_d = '0;
    busy_d     = (next_state != IDLE);
    case (next_state)
      LDI_T0: begin
        ra_in_d    = 1'b1;
        rega_imm_d = imm_d;
      end
      ADD_T1: begin
        ra_out_d  = 1'b1;
        rz_in_d   = 1'b1;
        add_imm_d = imm_d;
      end
      ADD_T2, MV_T0: begin
        rz_out_d = 1'b1;
        rb_in_d  = 1'b1;
      end
      FIN:     done_d    = 1'b1;
      ERR:     illegal_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state              <= IDLE;
      imm_q              <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      illegal            <= 1'b0;
      RAout              <= 1'b0;
      RBout              <= 1'b0;
      RZout              <= 1'b0;
      RAin               <= 1'b0;
      RBin               <= 1'b0;
      RZin               <= 1'b0;
      AddImmediate       <= '0;
      RegisterAImmediate <= '0;
    end else begin
      state              <= next_state;
      imm_q              <= imm_d;
      busy               <= busy_d;
      done               <= done_d;
      illegal            <= illegal_d;
      RAout              <= ra_out_d;
      RBout              <= rb_out_d;
      RZout              <= rz_out_d;
      RAin               <= ra_in_d;
      RBin               <= rb_in_d;
      RZin               <= rz_in_d;
      AddImmediate       <= add_imm_d;
      RegisterAImmediate <= rega_imm_d;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Randomized and directed stimulus for control_sequencer. A reference
//   model expands each accepted instruction into its list of per-cycle
//   output vectors; every clock edge pushes the expected vector into
//   exp_q and a monitor on the falling edge pops and compares it with the
//   DUT, together with bus-exclusivity and in/out conflict checks.
module tb_control_sequencer;
  localparam int W  = 8;
  localparam int VW = 9 + 2 * W;

  logic         clock = 1'b0;
  logic         clear, start;
  logic [1:0]   opcode;
  logic [W-1:0] imm;
  logic         busy, done, illegal;
  logic         RAout, RBout, RZout, RAin, RBin, RZin;
  logic [W-1:0] AddImmediate, RegisterAImmediate;
  logic [2:0]   state_dbg;

  control_sequencer #(.IMM_WIDTH(W)) dut (
    .clock              (clock),
    .clear              (clear),
    .start              (start),
    .opcode             (opcode),
    .imm                (imm),
    .busy               (busy),
    .done               (done),
    .illegal            (illegal),
    .RAout              (RAout),
    .RBout              (RBout),
    .RZout              (RZout),
    .RAin               (RAin),
    .RBin               (RBin),
    .RZin               (RZin),
    .AddImmediate       (AddImmediate),
    .RegisterAImmediate (RegisterAImmediate),
    .state_dbg          (state_dbg)
  );

  // clock / reset block: clear is driven by the stimulus below
  always #5 clock = ~clock;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] sched_q[$];
  logic [VW-1:0] cur_exp = '0;
  int vectors     = 0;
  int miscompares = 0;

  // vector layout: busy done illegal RAout RBout RZout RAin RBin RZin Add RegA
  function automatic logic [VW-1:0] mk(input logic b, input logic d, input logic il,
                                       input logic rao, input logic rbo, input logic rzo,
                                       input logic rai, input logic rbi, input logic rzi,
                                       input logic [W-1:0] add_v, input logic [W-1:0] rega_v);
    return {b, d, il, rao, rbo, rzo, rai, rbi, rzi, add_v, rega_v};
  endfunction

  // Reference model for one clock edge, from the instruction-level rules:
  // an idle sequencer (last output not busy) takes a request and plays out
  // that instruction's step list; after the list ends it goes idle.
  task automatic model_edge(input logic c, input logic s, input logic [1:0] op,
                            input logic [W-1:0] im);
    if (c) begin
      sched_q.delete();
      cur_exp = '0;
    end else begin
      if (!cur_exp[VW-1] && s) begin
        case (op)
          2'b00: begin
            sched_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, '0, im));
            sched_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, '0, '0));
          end
          2'b01: begin
            sched_q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, im, '0));
            sched_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, '0, '0));
            sched_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, '0, '0));
          end
          2'b10: begin
            sched_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, '0, '0));
            sched_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, '0, '0));
          end
          default: sched_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, '0, '0));
        endcase
      end
      if (sched_q.size() > 0) cur_exp = sched_q.pop_front();
      else                    cur_exp = '0;
    end
  endtask

  // driver: apply inputs, run the model on the edge, queue the expectation
  task automatic step(input logic c, input logic s, input logic [1:0] op,
                      input logic [W-1:0] im);
    clear  = c;
    start  = s;
    opcode = op;
    imm    = im;
    @(posedge clock);
    model_edge(c, s, op, im);
    exp_q.push_back(cur_exp);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, W'($urandom_range(0, 255)));
  endtask

  // scoreboard monitor
  logic [VW-1:0] mon_exp, mon_act;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {busy, done, illegal, RAout, RBout, RZout, RAin, RBin, RZin,
                 AddImmediate, RegisterAImmediate};
      vectors++;
      if (mon_act !== mon_exp) begin
        miscompares++;
        $display("FAIL outputs t=%0t got=%h required=%h (busy done ill RAo RBo RZo RAi RBi RZi add regA)",
                 $time, mon_act, mon_exp);
      end
      vectors++;
      if ($countones({RAout, RBout, RZout}) > 1) begin
        miscompares++;
        $display("FAIL bus_exclusive t=%0t got RAo/RBo/RZo=%b%b%b required at most one set",
                 $time, RAout, RBout, RZout);
      end
      vectors++;
      if ((RAin && RAout) || (RBin && RBout) || (RZin && RZout)) begin
        miscompares++;
        $display("FAIL in_out_conflict t=%0t got in=%b%b%b out=%b%b%b required no same-register pair",
                 $time, RAin, RBin, RZin, RAout, RBout, RZout);
      end
    end
  end

  initial begin
    clear  = 1'b1;
    start  = 1'b0;
    opcode = 2'b00;
    imm    = '0;

    // clear for two cycles, then LDI 05
    step(1'b1, 1'b0, 2'b00, 8'h00);
    step(1'b1, 1'b0, 2'b00, 8'h00);
    step(1'b0, 1'b1, 2'b00, 8'h05);
    idle(3);

    // ADDI 05
    step(1'b0, 1'b1, 2'b01, 8'h05);
    idle(4);

    // illegal opcode
    step(1'b0, 1'b1, 2'b11, 8'hAB);
    idle(3);

    // ADDI 0A with start held and opcode switched to LDI during ADD_T1
    step(1'b0, 1'b1, 2'b01, 8'h0A);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b00, 8'h77);
    idle(3);

    // clear during ADD_T2, then LDI 33
    step(1'b0, 1'b1, 2'b01, 8'h5C);
    step(1'b0, 1'b0, 2'b00, 8'h00);
    step(1'b1, 1'b0, 2'b00, 8'h00);
    step(1'b0, 1'b1, 2'b00, 8'h33);
    idle(3);

    // back-to-back LDI FF then MV with start held
    step(1'b0, 1'b1, 2'b00, 8'hFF);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b10, 8'h00);
    idle(3);

    // clear during FIN and during ERR
    step(1'b0, 1'b1, 2'b00, 8'h3C);
    step(1'b0, 1'b0, 2'b00, 8'h00);
    step(1'b1, 1'b0, 2'b00, 8'h00);
    step(1'b0, 1'b1, 2'b11, 8'h00);
    step(1'b1, 1'b0, 2'b00, 8'h00);
    idle(2);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
           2'($urandom_range(0, 3)), W'($urandom_range(0, 255)));
    end
    idle(4);

    repeat (2) @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
